call_stack_ctrl: RTL and testbench
==================================

Name: call_stack_ctrl

Overview:
ID-stage controller that initiates the register-file stack protocol for CALL/RET instructions. It drives push/pop and stack_pc, and arbitrates against the writeback write port. On RET it consumes the popped return address from read port 1. It issues a one-cycle PC redirect to the fetch stage and stalls ID while a call or return is in flight.

Parameters:
DEPTH, 4, maximum nested calls (stack entries in regfile, top at r7 growing down)
PC_W, 8, program counter width
DATA_W, 32, register-file data width
DEPTH_W, 3, width of depth counter (must hold 0..DEPTH)

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
id_call  in  1  decoded CALL in ID, qualified valid
id_ret  in  1  decoded RET in ID, qualified valid
id_pc  in  PC_W  PC of the instruction in ID
id_target  in  PC_W  CALL target address
wb_regwrite  in  1  writeback write in progress; regfile gives it priority over push/pop
rd1  in  DATA_W  regfile read port 1 (carries popped value the cycle after pop)
push  out  1  stack push request to regfile
pop  out  1  stack pop request to regfile
stack_pc  out  PC_W  PC handed to regfile on push (regfile stores stack_pc+1)
stall  out  1  hold ID/IF stages
pc_redirect  out  1  one-cycle redirect strobe to fetch
redirect_pc  out  PC_W  redirect destination
depth  out  DEPTH_W  current stack occupancy
overflow  out  1  sticky: CALL seen at depth==DEPTH
underflow  out  1  sticky: RET seen at depth==0
proto_err  out  1  sticky: id_call and id_ret asserted together

Behaviour:
- Reset (async): state IDLE; all outputs 0; depth 0; latched pc/target/return address 0; sticky flags cleared. Reset mid-operation aborts any pending push/pop without completing it.
- All outputs are registered or decoded from state only. No combinational path from id_* inputs to outputs.
- FSM states: IDLE, PUSH, POP, POP_RD, REDIR.
- IDLE, inputs sampled at posedge:
  - id_call & depth<DEPTH: latch id_pc to stack_pc and id_target to target; go to PUSH.
  - id_call & depth==DEPTH: set overflow; stay IDLE; no push, no redirect.
  - id_ret & depth>0: go to POP.
  - id_ret & depth==0: set underflow; stay IDLE.
  - id_call & id_ret together: set proto_err; CALL takes priority, RET is dropped.
- PUSH: push=1; stack_pc held. Push is held while wb_regwrite=1, because the regfile ignores it then. At the first cycle with wb_regwrite=0, the push completes: depth+1, redirect_pc<=target, go to REDIR.
- POP: pop=1, held while wb_regwrite=1. At the first cycle with wb_regwrite=0: depth-1, go to POP_RD.
- POP_RD: sample rd1[PC_W-1:0] into redirect_pc (the value already includes +1); ignore rd1 upper bits; go to REDIR.
- REDIR: pc_redirect=1 for exactly one cycle; go to IDLE.
- stall = (state != IDLE). id_call/id_ret are ignored outside IDLE.
- Nominal latency with no WB conflict, CALL sampled at edge 0:
  - CALL: push in cycle 1, pc_redirect in cycle 2, IDLE in cycle 3.
  - RET: pop in cycle 1, rd1 sampled in cycle 2, pc_redirect in cycle 3.
  - Each WB-conflict cycle adds one cycle.
- depth never wraps. Sticky flags clear only on reset.

Decomposition:
- Shared package: state encoding enum (IDLE/PUSH/POP/POP_RD/REDIR), DEPTH/PC_W/DATA_W defaults, STACK_TOP_REG=7 constant.
- No sub-module. The depth counter with saturating inc/dec is small enough to stay inline.

Test Plan:
- Reset then id_call, id_pc=0x10, id_target=0x40, wb_regwrite=0 -> push=1 with stack_pc=0x10 in cycle 1; pc_redirect=1, redirect_pc=0x40 in cycle 2; depth=1; stall high in cycles 1-2.
- After that call, id_ret with rd1 returning 0x11 the cycle after pop -> pop in cycle 1; redirect_pc=0x11 with pc_redirect in cycle 3; depth=0.
- id_call while wb_regwrite held high for 3 cycles -> push held 4 cycles, depth increments only once, redirect 1 cycle after wb_regwrite drops.
- 4 calls then a 5th call -> overflow=1, depth stays 4, no push, no redirect. RET at depth 0 after reset -> underflow=1, no pop.
- id_call and id_ret together at depth 1 -> proto_err=1 and the CALL proceeds (push, depth=2). Assert reset during POP -> pop=0, stall=0, depth=0, state IDLE immediately.

Source files
------------

// File: rtl/call_stack_ctrl_pkg.sv
// Shared types and defaults for the CALL/RET stack controller.
// Stack entries live in the regfile, top at r7 growing downward.
package call_stack_ctrl_pkg;

    localparam int unsigned DEPTH_DEF     = 4;
    localparam int unsigned PC_W_DEF      = 8;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned DEPTH_W_DEF   = 3;
    localparam int unsigned STACK_TOP_REG = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUSH   = 3'd1,
        POP    = 3'd2,
        POP_RD = 3'd3,
        REDIR  = 3'd4
    } cs_state_t;

endpackage

// File: rtl/call_stack_ctrl.sv
// ID-stage CALL/RET controller: drives regfile push/pop, stalls ID,
// and issues a one-cycle PC redirect to fetch.
module call_stack_ctrl
    import call_stack_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH_W = DEPTH_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_call,
    input  logic               id_ret,
    input  logic [PC_W-1:0]    id_pc,
    input  logic [PC_W-1:0]    id_target,
    input  logic               wb_regwrite,
    input  logic [DATA_W-1:0]  rd1,
    output logic               push,
    output logic               pop,
    output logic [PC_W-1:0]    stack_pc,
    output logic               stall,
    output logic               pc_redirect,
    output logic [PC_W-1:0]    redirect_pc,
    output logic [DEPTH_W-1:0] depth,
    output logic               overflow,
    output logic               underflow,
    output logic               proto_err
);

    localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(DEPTH);

    cs_state_t          r_state;
    logic               r_push;
    logic               r_pop;
    logic               r_stall;
    logic               r_redirect;
    logic [PC_W-1:0]    r_stack_pc;
    logic [PC_W-1:0]    r_target;
    logic [PC_W-1:0]    r_redirect_pc;
    logic [DEPTH_W-1:0] r_depth;
    logic               r_overflow;
    logic               r_underflow;
    logic               r_proto_err;

    // Upper rd1 bits carry no return-address information.
    logic w_rd1_hi_unused;
    assign w_rd1_hi_unused = ^rd1[DATA_W-1:PC_W];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_push        <= 1'b0;
            r_pop         <= 1'b0;
            r_stall       <= 1'b0;
            r_redirect    <= 1'b0;
            r_stack_pc    <= '0;
            r_target      <= '0;
            r_redirect_pc <= '0;
            r_depth       <= '0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_proto_err   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (id_call && id_ret)
                        r_proto_err <= 1'b1;
                    if (id_call) begin
                        if (r_depth < DMAX) begin
                            r_stack_pc <= id_pc;
                            r_target   <= id_target;
                            r_push     <= 1'b1;
                            r_stall    <= 1'b1;
                            r_state    <= PUSH;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else if (id_ret) begin
                        if (r_depth != '0) begin
                            r_pop   <= 1'b1;
                            r_stall <= 1'b1;
                            r_state <= POP;
                        end else begin
                            r_underflow <= 1'b1;
                        end
                    end
                end
                // Regfile ignores push/pop while writeback owns the port.
                PUSH: begin
                    if (!wb_regwrite) begin
                        r_push        <= 1'b0;
                        if (r_depth < DMAX)
                            r_depth <= r_depth + 1'b1;
                        r_redirect_pc <= r_target;
                        r_redirect    <= 1'b1;
                        r_state       <= REDIR;
                    end
                end
                POP: begin
                    if (!wb_regwrite) begin
                        r_pop   <= 1'b0;
                        if (r_depth != '0)
                            r_depth <= r_depth - 1'b1;
                        r_state <= POP_RD;
                    end
                end
                POP_RD: begin
                    r_redirect_pc <= rd1[PC_W-1:0];
                    r_redirect    <= 1'b1;
                    r_state       <= REDIR;
                end
                REDIR: begin
                    r_redirect <= 1'b0;
                    r_stall    <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_push     <= 1'b0;
                    r_pop      <= 1'b0;
                    r_redirect <= 1'b0;
                    r_stall    <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign push        = r_push;
    assign pop         = r_pop;
    assign stack_pc    = r_stack_pc;
    assign stall       = r_stall;
    assign pc_redirect = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign depth       = r_depth;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Directed bench for call_stack_ctrl: call/ret timing, WB conflicts,
// overflow/underflow/proto_err flags and asynchronous reset mid-pop.
module tb_call_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_call;
    logic        id_ret;
    logic [7:0]  id_pc;
    logic [7:0]  id_target;
    logic        wb_regwrite;
    logic [31:0] rd1;
    logic        push;
    logic        pop;
    logic [7:0]  stack_pc;
    logic        stall;
    logic        pc_redirect;
    logic [7:0]  redirect_pc;
    logic [2:0]  depth;
    logic        overflow;
    logic        underflow;
    logic        proto_err;

    int passed = 0;
    int total  = 0;

    call_stack_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .id_call     (id_call),
        .id_ret      (id_ret),
        .id_pc       (id_pc),
        .id_target   (id_target),
        .wb_regwrite (wb_regwrite),
        .rd1         (rd1),
        .push        (push),
        .pop         (pop),
        .stack_pc    (stack_pc),
        .stall       (stall),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .depth       (depth),
        .overflow    (overflow),
        .underflow   (underflow),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt);
        id_call   = 1'b1;
        id_pc     = pc;
        id_target = tgt;
        step();
        id_call = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset       = 1'b1;
        id_call     = 1'b0;
        id_ret      = 1'b0;
        id_pc       = '0;
        id_target   = '0;
        wb_regwrite = 1'b0;
        rd1         = '0;
        step();
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_redir", 32'(pc_redirect), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_flags", {29'd0, overflow, underflow, proto_err}, 32'd0);
        reset = 1'b0;
        step();

        // Plain CALL
        id_call   = 1'b1;
        id_pc     = 8'h10;
        id_target = 8'h40;
        step();
        id_call = 1'b0;
        chk("call_c1_push", 32'(push), 32'd1);
        chk("call_c1_spc", 32'(stack_pc), 32'h10);
        chk("call_c1_stall", 32'(stall), 32'd1);
        chk("call_c1_redir", 32'(pc_redirect), 32'd0);
        step();
        chk("call_c2_push", 32'(push), 32'd0);
        chk("call_c2_redir", 32'(pc_redirect), 32'd1);
        chk("call_c2_rpc", 32'(redirect_pc), 32'h40);
        chk("call_c2_depth", 32'(depth), 32'd1);
        chk("call_c2_stall", 32'(stall), 32'd1);
        step();
        chk("call_c3_stall", 32'(stall), 32'd0);
        chk("call_c3_redir", 32'(pc_redirect), 32'd0);

        // Plain RET, upper rd1 bits are garbage
        id_ret = 1'b1;
        step();
        id_ret = 1'b0;
        chk("ret_c1_pop", 32'(pop), 32'd1);
        chk("ret_c1_stall", 32'(stall), 32'd1);
        step();
        rd1 = 32'hABCDEF11;
        chk("ret_c2_pop", 32'(pop), 32'd0);
        chk("ret_c2_depth", 32'(depth), 32'd0);
        chk("ret_c2_redir", 32'(pc_redirect), 32'd0);
        step();
        rd1 = '0;
        chk("ret_c3_redir", 32'(pc_redirect), 32'd1);
        chk("ret_c3_rpc", 32'(redirect_pc), 32'h11);
        step();
        chk("ret_c4_stall", 32'(stall), 32'd0);
        chk("ret_c4_redir", 32'(pc_redirect), 32'd0);

        // CALL against a 3-cycle writeback conflict
        id_call     = 1'b1;
        id_pc       = 8'h20;
        id_target   = 8'h55;
        wb_regwrite = 1'b1;
        step();
        id_call = 1'b0;
        chk("wb_c1_push", 32'(push), 32'd1);
        step();
        chk("wb_c2_push", 32'(push), 32'd1);
        step();
        chk("wb_c3_push", 32'(push), 32'd1);
        chk("wb_c3_depth", 32'(depth), 32'd0);
        step();
        wb_regwrite = 1'b0;
        chk("wb_c4_push", 32'(push), 32'd1);
        chk("wb_c4_redir", 32'(pc_redirect), 32'd0);
        step();
        chk("wb_c5_push", 32'(push), 32'd0);
        chk("wb_c5_redir", 32'(pc_redirect), 32'd1);
        chk("wb_c5_rpc", 32'(redirect_pc), 32'h55);
        chk("wb_c5_depth", 32'(depth), 32'd1);
        step();
        chk("wb_c6_depth", 32'(depth), 32'd1);
        chk("wb_c6_stall", 32'(stall), 32'd0);

        // CALL and RET together at depth 1
        id_call   = 1'b1;
        id_ret    = 1'b1;
        id_pc     = 8'h30;
        id_target = 8'h60;
        step();
        id_call = 1'b0;
        id_ret  = 1'b0;
        chk("both_perr", 32'(proto_err), 32'd1);
        chk("both_push", 32'(push), 32'd1);
        chk("both_pop", 32'(pop), 32'd0);
        chk("both_spc", 32'(stack_pc), 32'h30);
        step();
        chk("both_rpc", 32'(redirect_pc), 32'h60);
        chk("both_depth", 32'(depth), 32'd2);
        step();

        // Fill to DEPTH then overflow
        do_call(8'h31, 8'h70);
        do_call(8'h32, 8'h80);
        chk("full_depth", 32'(depth), 32'd4);
        chk("full_ovf0", 32'(overflow), 32'd0);
        id_call   = 1'b1;
        id_pc     = 8'h33;
        id_target = 8'h90;
        step();
        id_call = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_push", 32'(push), 32'd0);
        chk("ovf_stall", 32'(stall), 32'd0);
        chk("ovf_depth", 32'(depth), 32'd4);
        step();
        chk("ovf_redir", 32'(pc_redirect), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset during POP
        id_ret = 1'b1;
        step();
        id_ret = 1'b0;
        chk("mid_pop", 32'(pop), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_pop", 32'(pop), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_depth", 32'(depth), 32'd0);
        chk("mid_rst_flags", {29'd0, overflow, underflow, proto_err}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_pop", 32'(pop), 32'd0);

        // RET at depth 0
        id_ret = 1'b1;
        step();
        id_ret = 1'b0;
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_pop", 32'(pop), 32'd0);
        chk("unf_stall", 32'(stall), 32'd0);
        step();
        chk("unf_redir", 32'(pc_redirect), 32'd0);
        chk("unf_depth", 32'(depth), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
